// File: rtl/piano_pong_test_pkg.sv
// Shared definitions for the datapath test harness: checker FSM encoding and result codes.
package piano_pong_test_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_FLAGS   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [15:0] PASS_CODE = 16'h600D;

  // Harness-default geometry; the checker derives width-generic versions from its parameters.
  localparam int unsigned DEF_NUM_REGS  = 16;
  localparam int unsigned DEF_REG_IDX_W = 6;
  localparam logic [5:0]  NO_FAIL       = 6'h3F;
  localparam logic [5:0]  FLAG_IDX      = 6'd16;

endpackage

// File: rtl/reg_readback_checker.sv
// Reads every register of alu_and_reg back through its read port, compares it (and the final
// flags) against an expected table, and publishes pass/fail status plus a display summary word.
module reg_readback_checker
  import piano_pong_test_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_IDX_W = DEF_REG_IDX_W,
  parameter int DATA_W    = 16,
  parameter int FLAG_W    = 5,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] reg_read_number,
  input  logic [DATA_W-1:0]    reg_read_data,
  input  logic [FLAG_W-1:0]    flags,
  input  logic [DATA_W-1:0]    exp_data,
  input  logic [FLAG_W-1:0]    exp_flags,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           fail_count,
  output logic [REG_IDX_W-1:0] first_fail,
  output logic [DATA_W-1:0]    display
);

  localparam logic [REG_IDX_W-1:0] NoFail  = '1;
  localparam logic [REG_IDX_W-1:0] FlagIdx = REG_IDX_W'(NUM_REGS);
  localparam logic [REG_IDX_W-1:0] LastIdx = REG_IDX_W'(NUM_REGS - 1);
  localparam int CntW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
  localparam logic [CntW-1:0] WaitLoad = CntW'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]           state;
  logic [CntW-1:0]      wait_cnt;
  logic                 hit;
  logic [REG_IDX_W-1:0] rec_idx;
  logic [7:0]           fail_next;
  logic [REG_IDX_W-1:0] first_next;

  // Mismatch bookkeeping for the current COMPARE or FLAGS cycle.
  always_comb begin
    hit     = 1'b0;
    rec_idx = reg_read_number;
    if (state == ST_COMPARE) begin
      hit = (reg_read_data != exp_data);
    end else if (state == ST_FLAGS) begin
      hit     = (flags != exp_flags);
      rec_idx = FlagIdx;
    end
    fail_next  = hit ? sat_inc8(fail_count) : fail_count;
    first_next = (hit && first_fail == NoFail) ? rec_idx : first_fail;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      wait_cnt        <= '0;
      reg_read_number <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_count      <= 8'd0;
      first_fail      <= NoFail;
      display         <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_ISSUE;
            reg_read_number <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= 8'd0;
            first_fail      <= NoFail;
            display         <= '0;
          end
        end
        ST_ISSUE: begin
          if (READ_LAT == 1) begin
            state <= ST_COMPARE;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WaitLoad;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) state <= ST_COMPARE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        ST_COMPARE: begin
          fail_count <= fail_next;
          first_fail <= first_next;
          if (reg_read_number == LastIdx) begin
            state <= ST_FLAGS;
          end else begin
            reg_read_number <= reg_read_number + 1'b1;
            state           <= ST_ISSUE;
          end
        end
        ST_FLAGS: begin
          fail_count <= fail_next;
          first_fail <= first_next;
          state      <= ST_DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          pass       <= (fail_next == 8'd0);
          // Summary word: fail count in the upper byte, first failing index in the lower byte.
          display    <= (fail_next == 8'd0) ? DATA_W'(PASS_CODE)
                                            : DATA_W'({fail_next, 8'(first_next)});
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readback_checker.sv
// Directed bench for reg_readback_checker: one instance at READ_LAT=1, one at READ_LAT=3.
module tb_reg_readback_checker;

  localparam int NR = 16;
  localparam int IW = 6;
  localparam int DW = 16;
  localparam int FW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start1, start3;
  logic [IW-1:0] num1, num3, ff1, ff3;
  logic [DW-1:0] rd1, rd3, ed1, ed3, disp1, disp3, p0, p1;
  logic [FW-1:0] flags, exp_flags;
  logic          busy1, done1, pass1, busy3, done3, pass3;
  logic [7:0]    fc1, fc3;
  logic [DW-1:0] regs    [64];
  logic [DW-1:0] exp_tab [64];
  int checks = 0;
  int errors = 0;

  assign ed1 = exp_tab[num1];
  assign ed3 = exp_tab[num3];

  // Register-file read port models: 1-cycle and 3-cycle latency from index change.
  always @(posedge clk) begin
    rd1 <= regs[num1];
    p0  <= regs[num3];
    p1  <= p0;
    rd3 <= p1;
  end

  reg_readback_checker #(.NUM_REGS(NR), .REG_IDX_W(IW), .DATA_W(DW), .FLAG_W(FW), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .reg_read_number(num1), .reg_read_data(rd1),
    .flags(flags), .exp_data(ed1), .exp_flags(exp_flags), .busy(busy1), .done(done1),
    .pass(pass1), .fail_count(fc1), .first_fail(ff1), .display(disp1));

  reg_readback_checker #(.NUM_REGS(NR), .REG_IDX_W(IW), .DATA_W(DW), .FLAG_W(FW), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .reg_read_number(num3), .reg_read_data(rd3),
    .flags(flags), .exp_data(ed3), .exp_flags(exp_flags), .busy(busy3), .done(done3),
    .pass(pass3), .fail_count(fc3), .first_fail(ff3), .display(disp3));

  task automatic init_tables();
    for (int i = 0; i < 64; i++) begin
      regs[i]    = 16'h1000 + 16'(i * 273);
      exp_tab[i] = regs[i];
    end
    flags     = 5'b00000;
    exp_flags = 5'b00000;
  endtask

  task automatic pulse1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    init_tables();
    repeat (2) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (ff1 !== 6'h3F) begin errors++; $display("FAIL reset_first_fail: got %h expected 3f", ff1); end
    checks++; if (disp1 !== 16'h0000) begin errors++; $display("FAIL reset_display: got %h expected 0000", disp1); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset_mid_check();
    int n;
    init_tables();
    regs[2] = 16'hDEAD;
    pulse1();
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({busy1, done1, pass1} !== 3'b000) begin errors++; $display("FAIL midreset_status: got %b expected 000", {busy1, done1, pass1}); end
    checks++; if (fc1 !== 8'd0 || ff1 !== 6'h3F) begin errors++; $display("FAIL midreset_results: got %h/%h expected 00/3f", fc1, ff1); end
    checks++; if (num1 !== 6'd0 || disp1 !== 16'h0) begin errors++; $display("FAIL midreset_idx_disp: got %h/%h expected 00/0000", num1, disp1); end
    @(negedge clk) reset = 1'b1;
    regs[2] = exp_tab[2];
    pulse1();
    wait_done1(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL midreset_rerun_latency: got %0d expected 33", n); end
    checks++; if (pass1 !== 1'b1 || disp1 !== 16'h600D) begin errors++; $display("FAIL midreset_rerun_pass: got %b/%h expected 1/600d", pass1, disp1); end
  endtask

  task automatic test_all_match();
    int n;
    init_tables();
    pulse1();
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL match_busy: got %b expected 1", busy1); end
    wait_done1(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL match_latency: got %0d expected 33", n); end
    checks++; if (pass1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL match_pass_busy: got %b/%b expected 1/0", pass1, busy1); end
    checks++; if (fc1 !== 8'd0 || ff1 !== 6'h3F) begin errors++; $display("FAIL match_results: got %h/%h expected 00/3f", fc1, ff1); end
    checks++; if (disp1 !== 16'h600D) begin errors++; $display("FAIL match_display: got %h expected 600d", disp1); end
  endtask

  task automatic test_reg_mismatch();
    int n;
    init_tables();
    regs[3] = regs[3] ^ 16'h0001;
    regs[9] = regs[9] ^ 16'h8000;
    pulse1();
    wait_done1(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL regmis_latency: got %0d expected 33", n); end
    checks++; if (fc1 !== 8'd2 || ff1 !== 6'd3) begin errors++; $display("FAIL regmis_results: got %h/%h expected 02/03", fc1, ff1); end
    checks++; if (pass1 !== 1'b0 || disp1 !== 16'h0203) begin errors++; $display("FAIL regmis_display: got %b/%h expected 0/0203", pass1, disp1); end
  endtask

  task automatic test_flag_mismatch();
    int n;
    init_tables();
    flags = 5'b00010;
    pulse1();
    wait_done1(n);
    checks++; if (fc1 !== 8'd1 || ff1 !== 6'd16) begin errors++; $display("FAIL flagmis_results: got %h/%h expected 01/10", fc1, ff1); end
    checks++; if (pass1 !== 1'b0 || disp1 !== 16'h0110) begin errors++; $display("FAIL flagmis_display: got %b/%h expected 0/0110", pass1, disp1); end
    flags = 5'b00000;
  endtask

  task automatic test_read_latency3();
    int n;
    init_tables();
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    n = 0;
    while (!done3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL lat3_latency: got %0d expected 65", n); end
    checks++; if (pass3 !== 1'b1 || fc3 !== 8'd0 || ff3 !== 6'h3F || disp3 !== 16'h600D) begin
      errors++; $display("FAIL lat3_results: got %b/%h/%h/%h expected 1/00/3f/600d", pass3, fc3, ff3, disp3);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    init_tables();
    for (int i = 0; i < NR; i++) regs[i] = ~exp_tab[i];
    flags = 5'b10101;
    pulse1();
    repeat (4) @(negedge clk);
    pulse1();
    wait_done1(n);
    checks++; if (n !== 27) begin errors++; $display("FAIL b2b_ignore_start: got %0d expected 27", n); end
    checks++; if (fc1 !== 8'd17 || ff1 !== 6'd0 || disp1 !== 16'h1100) begin
      errors++; $display("FAIL b2b_all_fail: got %h/%h/%h expected 11/00/1100", fc1, ff1, disp1);
    end
    pulse1();
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || fc1 !== 8'd0 || ff1 !== 6'h3F || disp1 !== 16'h0) begin
      errors++; $display("FAIL b2b_restart_clear: got %b/%b/%h/%h/%h expected 1/0/00/3f/0000", busy1, done1, fc1, ff1, disp1);
    end
    wait_done1(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_rerun_latency: got %0d expected 33", n); end
    checks++; if (fc1 !== 8'd17 || ff1 !== 6'd0 || disp1 !== 16'h1100 || pass1 !== 1'b0) begin
      errors++; $display("FAIL b2b_rerun_results: got %h/%h/%h/%b expected 11/00/1100/0", fc1, ff1, disp1, pass1);
    end
    flags = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_reset_mid_check();
    test_all_match();
    test_reg_mismatch();
    test_flag_mismatch();
    test_read_latency3();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
